ex_ctrl: RTL and testbench

EX_CTRL -- requirements
Module: ex_ctrl

---
 rtl/ex_ctrl.sv | 90 +++++++++
 tb/tb_ex_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_ctrl.sv
// ex_ctrl: single-issue ALU execute controller (IDLE/ISSUE/WAIT/WB), optional WAIT timeout via EX_CTRL_TIMEOUT_EN
module ex_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        special_enc,
  input  logic [1:0]  ld1,
  input  logic [2:0]  alu_oc,
  input  logic [2:0]  dest_reg,
  input  logic [15:0] op1_val,
  input  logic [15:0] op2_val,
  input  logic [15:0] immediate,
  output logic        alu_start,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic [3:0]  flags,
`ifdef EX_CTRL_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] WB = 2'd3;
  logic [1:0] state;
  logic       accept;
  logic       ld1_unused;
`ifdef EX_CTRL_TIMEOUT_EN
  logic [3:0] wait_cnt;
`endif
  assign ld1_unused = ld1[1];
  assign accept = in_valid && special_enc && alu_oc != 3'd0 && alu_oc != 3'd7;
  assign in_ready = !rst && state == IDLE;
  assign alu_start = !rst && state == ISSUE;
  assign wb_valid = !rst && state == WB;
  assign busy = !rst && state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      wb_reg <= '0;
      wb_data <= '0;
      flags <= '0;
`ifdef EX_CTRL_TIMEOUT_EN
      wait_cnt <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_a <= op1_val;
          alu_b <= ld1[0] ? immediate : op2_val;
          alu_op <= alu_oc;
          wb_reg <= dest_reg;
          state <= ISSUE;
        end
        ISSUE, WAIT: if (alu_done) begin
          wb_data <= alu_result;
          flags <= alu_flags;
          state <= WB;
        end else begin
`ifdef EX_CTRL_TIMEOUT_EN
          if (state == WAIT && wait_cnt == 4'd14) begin
            timeout_err <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= state == WAIT ? wait_cnt + 4'd1 : 4'd0;
            state <= WAIT;
          end
`else
          state <= WAIT;
`endif
        end
        default: if (wb_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_ctrl.sv
// tb_ex_ctrl: directed self-checking bench for ex_ctrl
module tb_ex_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, special_enc;
  logic [1:0]  ld1;
  logic [2:0]  alu_oc, dest_reg, alu_op, wb_reg;
  logic [15:0] op1_val, op2_val, immediate, alu_a, alu_b, alu_result, wb_data;
  logic        alu_start, alu_done, wb_valid, wb_ready, busy;
  logic [3:0]  alu_flags, flags;
`ifdef EX_CTRL_TIMEOUT_EN
  logic        timeout_err;
`endif
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  ex_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .special_enc(special_enc), .ld1(ld1), .alu_oc(alu_oc), .dest_reg(dest_reg),
    .op1_val(op1_val), .op2_val(op2_val), .immediate(immediate),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .flags(flags),
`ifdef EX_CTRL_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [2:0] oc, input logic [1:0] l, input logic [2:0] d,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] im);
    in_valid = 1'b1;
    special_enc = 1'b1;
    alu_oc = oc;
    ld1 = l;
    dest_reg = d;
    op1_val = a;
    op2_val = b;
    immediate = im;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    special_enc = 1'b0;
    ld1 = 2'b00;
    alu_oc = 3'd0;
    dest_reg = 3'd0;
    op1_val = '0;
    op2_val = '0;
    immediate = '0;
    alu_done = 1'b0;
    alu_result = '0;
    alu_flags = '0;
    wb_ready = 1'b0;
    tick;
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    chk("rst_alu_start", 16'(alu_start), 16'h0);
    chk("rst_wb_valid", 16'(wb_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_flags", 16'(flags), 16'h0);
    chk("rst_alu_a", alu_a, 16'h0);
    chk("rst_alu_b", alu_b, 16'h0);
    chk("rst_wb_data", wb_data, 16'h0);
    chk("rst_alu_op", 16'(alu_op), 16'h0);
    chk("rst_wb_reg", 16'(wb_reg), 16'h0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 16'(in_ready), 16'h1);
    // ADD immediate at minimum latency
    instr(3'd1, 2'b01, 3'd3, 16'h0005, 16'h0077, 16'h0003);
    tick;
    in_valid = 1'b0;
    chk("add_start", 16'(alu_start), 16'h1);
    chk("add_alu_a", alu_a, 16'h0005);
    chk("add_alu_b", alu_b, 16'h0003);
    chk("add_alu_op", 16'(alu_op), 16'h1);
    chk("add_in_ready", 16'(in_ready), 16'h0);
    chk("add_busy", 16'(busy), 16'h1);
    alu_done = 1'b1;
    alu_result = 16'h0008;
    alu_flags = 4'b0000;
    tick;
    alu_done = 1'b0;
    chk("add_wb_valid", 16'(wb_valid), 16'h1);
    chk("add_wb_data", wb_data, 16'h0008);
    chk("add_wb_reg", 16'(wb_reg), 16'h3);
    chk("add_start_once", 16'(alu_start), 16'h0);
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    chk("add_wb_drop", 16'(wb_valid), 16'h0);
    chk("add_back_idle", 16'(in_ready), 16'h1);
    // SUB register operand, ALU done after three WAIT cycles
    instr(3'd2, 2'b00, 3'd5, 16'h0001, 16'h0002, 16'h00AA);
    tick;
    in_valid = 1'b0;
    chk("sub_start", 16'(alu_start), 16'h1);
    chk("sub_alu_b", alu_b, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("sub_wait_start", 16'(alu_start), 16'h0);
      chk("sub_wait_flags", 16'(flags), 16'h0);
      chk("sub_wait_alu_a", alu_a, 16'h0001);
      chk("sub_wait_alu_b", alu_b, 16'h0002);
      chk("sub_wait_wb", 16'(wb_valid), 16'h0);
    end
    alu_done = 1'b1;
    alu_result = 16'hFFFF;
    alu_flags = 4'b1000;
    tick;
    chk("sub_flags", 16'(flags), 16'h8);
    chk("sub_wb_data", wb_data, 16'hFFFF);
    chk("sub_wb_reg", 16'(wb_reg), 16'h5);
    // backpressure with stray alu_done and a pending instruction
    alu_result = 16'h1234;
    alu_flags = 4'b0001;
    instr(3'd3, 2'b00, 3'd1, 16'h0F0F, 16'h00FF, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_wb_valid", 16'(wb_valid), 16'h1);
      chk("bp_wb_data", wb_data, 16'hFFFF);
      chk("bp_in_ready", 16'(in_ready), 16'h0);
      chk("bp_flags", 16'(flags), 16'h8);
    end
    in_valid = 1'b0;
    alu_done = 1'b0;
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    chk("bp_release_idle", 16'(in_ready), 16'h1);
    chk("bp_release_wb", 16'(wb_valid), 16'h0);
    chk("bp_release_busy", 16'(busy), 16'h0);
    alu_done = 1'b1;
    alu_flags = 4'b0110;
    tick;
    alu_done = 1'b0;
    chk("idle_done_flags", 16'(flags), 16'h8);
    chk("idle_done_busy", 16'(busy), 16'h0);
    // NOPs: non-ALU class and reserved opcodes
    instr(3'd1, 2'b00, 3'd2, 16'h1111, 16'h2222, 16'h0);
    special_enc = 1'b0;
    tick;
    chk("nop_enc_start", 16'(alu_start), 16'h0);
    chk("nop_enc_ready", 16'(in_ready), 16'h1);
    chk("nop_enc_alu_a", alu_a, 16'h0001);
    instr(3'd0, 2'b00, 3'd2, 16'h1111, 16'h2222, 16'h0);
    tick;
    chk("nop_000_busy", 16'(busy), 16'h0);
    instr(3'd7, 2'b00, 3'd2, 16'h1111, 16'h2222, 16'h0);
    tick;
    in_valid = 1'b0;
    chk("nop_111_busy", 16'(busy), 16'h0);
    chk("nop_wb", 16'(wb_valid), 16'h0);
    chk("nop_flags", 16'(flags), 16'h8);
    // XOR immediate, flags verbatim
    instr(3'd5, 2'b01, 3'd7, 16'h0F0F, 16'h1234, 16'h00FF);
    tick;
    in_valid = 1'b0;
    chk("xor_alu_b", alu_b, 16'h00FF);
    chk("xor_alu_op", 16'(alu_op), 16'h5);
    alu_done = 1'b1;
    alu_result = 16'h0FF0;
    alu_flags = 4'b0111;
    wb_ready = 1'b1;
    tick;
    alu_done = 1'b0;
    chk("xor_flags", 16'(flags), 16'h7);
    chk("xor_wb_data", wb_data, 16'h0FF0);
    chk("xor_wb_reg", 16'(wb_reg), 16'h7);
    tick;
    wb_ready = 1'b0;
    chk("xor_idle", 16'(in_ready), 16'h1);
    // reset while waiting for the ALU
    instr(3'd4, 2'b00, 3'd4, 16'hA000, 16'h000A, 16'h0);
    tick;
    in_valid = 1'b0;
    tick;
    chk("rstw_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    alu_done = 1'b1;
    alu_result = 16'hA00A;
    alu_flags = 4'b1111;
    wb_ready = 1'b1;
    #1;
    chk("rstw_in_ready", 16'(in_ready), 16'h0);
    chk("rstw_busy_rst", 16'(busy), 16'h0);
    tick;
    rst = 1'b0;
    #1;
    chk("rstw_flags", 16'(flags), 16'h0);
    chk("rstw_wb", 16'(wb_valid), 16'h0);
    chk("rstw_in_ready_after", 16'(in_ready), 16'h1);
    tick;
    alu_done = 1'b0;
    wb_ready = 1'b0;
    chk("rstw_wb_late", 16'(wb_valid), 16'h0);
    chk("rstw_flags_late", 16'(flags), 16'h0);
    chk("rstw_wb_data", wb_data, 16'h0);
    // reset wins over a simultaneous accept
    instr(3'd1, 2'b01, 3'd6, 16'h4444, 16'h0, 16'h0001);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstp_busy", 16'(busy), 16'h0);
    chk("rstp_alu_a", alu_a, 16'h0);
`ifdef EX_CTRL_TIMEOUT_EN
    instr(3'd1, 2'b00, 3'd2, 16'h0001, 16'h0001, 16'h0);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("to_busy", 16'(busy), 16'h1);
      chk("to_err_early", 16'(timeout_err), 16'h0);
    end
    tick;
    chk("to_err", 16'(timeout_err), 16'h1);
    chk("to_in_ready", 16'(in_ready), 16'h1);
    chk("to_wb", 16'(wb_valid), 16'h0);
    chk("to_flags", 16'(flags), 16'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
